instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Upstream feeder for the 9-bit bus processor.
- Walks a program counter through a synchronous instruction ROM and presents each instruction on DIN with a one-cycle Run pulse.
- For mvi, supplies the immediate word on the following cycle, then waits for Done before fetching the next instruction.
- Sits between the program ROM and the processor's DIN/Run/Done pins.

Parameters:
- ADDR_W, 5, ROM address width; program space is 2^ADDR_W words.
- OPC_MVI, 3'b001, opcode value (instruction bits [8:6]) that carries a trailing immediate word.
- TIMEOUT, 15, cycles to wait for Done before flagging an error (used only with the optional feature).

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Go  in  1  level; while high, fetch and issue instructions back to back.
- ADDR  out  ADDR_W  ROM address; combinational from PC and state.
- ROM_DATA  in  9  ROM read data; valid the cycle after ADDR is presented (1-cycle synchronous ROM).
- Done  in  1  processor instruction-complete strobe.
- DIN  out  9  instruction/immediate to processor; 0 when not driving.
- Run  out  1  one-cycle issue strobe to processor.
- Busy  out  1  high in every state except IDLE.
- PC  out  ADDR_W  current program counter, for debug.
- Error  out  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset (async, Resetn=0): state IDLE, PC=0, Run=0, DIN=0, Busy=0, Error=0. ADDR equals PC (0).
- States: IDLE, FETCH, ISSUE, IMM, WAIT_DONE.
- IDLE:
  - ADDR=PC.
  - Go=1 -> FETCH. Otherwise stay.
- FETCH:
  - ADDR=PC.
  - Next cycle -> ISSUE (ROM_DATA now valid).
- ISSUE:
  - DIN=ROM_DATA, Run=1 for exactly this cycle.
  - ADDR=PC+1 (wraps mod 2^ADDR_W).
  - If ROM_DATA[8:6]==OPC_MVI: PC<=PC+1, -> IMM.
  - Otherwise -> WAIT_DONE.
- IMM:
  - DIN=ROM_DATA (immediate, aligned with processor time step T1), Run=0.
  - Done=1 this cycle: PC<=PC+1, -> FETCH if Go else IDLE.
  - Otherwise -> WAIT_DONE.
- WAIT_DONE:
  - DIN=0, Run=0, ADDR=PC.
  - Done=1: PC<=PC+1, -> FETCH if Go else IDLE.
- Issue latency: 2 cycles from Go rising (IDLE) to Run.
- Throughput: mv issues every 3 cycles (ISSUE, Done in WAIT_DONE, FETCH); add/sub every 5.
- PC wrap: 2^ADDR_W-1 increments to 0. An mvi at the last address takes its immediate from address 0 and resumes at address 1.
- Go deasserted mid-instruction: the current instruction (including its immediate) completes; the block returns to IDLE after Done. The PC points at the next instruction, so resuming continues in program order.
- Done outside IMM/WAIT_DONE (IDLE, FETCH, ISSUE): ignored.
- Done in the same cycle as Go falling: transition goes to IDLE.
- Reset mid-operation: immediate return to reset values. A Run pulse already in flight is not retracted; the processor is reset by the same Resetn.

Optional Feature:
- Macro: INSTR_FETCH_WATCHDOG_EN.
- Defined:
  - An ADDR_W-independent 4-bit+ counter clears on entry to IMM/WAIT_DONE and counts each cycle without Done.
  - Reaching TIMEOUT sets Error (sticky until reset) and forces IDLE. While Error=1, Go is ignored.
- Undefined: no counter; the block waits for Done indefinitely; Error is constant 0.

Decomposition:
- Shared package proc_pkg:
  - opcode constants (mv=3'b000, mvi=3'b001, add=3'b010, sub=3'b011)
  - instruction field positions (opcode [8:6], X [5:3], Y [2:0])
  - word width 9
  - fetch state encoding
- Sub-module pc_counter: ADDR_W-bit loadable, wrap-around incrementer with increment enable and async clear. Also provides PC+1 combinationally for the ISSUE look-ahead.

Test Plan:
- ROM[0]=9'b000_001_010 (mv R1,R2), Go=1, Done pulsed the cycle after Run -> Run high exactly cycle 2 with DIN=0x00A; PC 0->1; next Run at cycle 5.
- ROM[0]=9'b001_011_000 (mvi R3), ROM[1]=0x1A5, Done in IMM cycle -> DIN=0x058 with Run=1, next cycle DIN=0x1A5 with Run=0; next fetch from address 2.
- ADDR_W=5, ROM[31]=mvi, ROM[0]=0x07F, PC preset by running to 31 -> immediate read from ADDR=0, DIN=0x07F, PC becomes 1.
- add instruction with Done 3 cycles after Run and Go dropped during WAIT_DONE -> exactly one Run pulse; Busy falls the cycle after Done; PC=1; Go re-raised later issues from address 1.
- Resetn pulsed low during IMM -> Run=0, DIN=0, PC=0, Busy=0 immediately (asynchronously), before the next clock edge.
- With INSTR_FETCH_WATCHDOG_EN, TIMEOUT=15, Done never asserted -> Error=1 on the 15th wait cycle, state IDLE, Go=1 produces no further Run; without the macro, Error stays 0 and Busy stays 1.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit bus processor and its instruction feeder.
// Contents: word width, opcode constants, instruction field positions,
// fetch FSM state encoding and a small opcode-extract helper.
package proc_pkg;

    localparam int WORD_W = 9;

    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_MVI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;

    // Instruction layout: opcode [8:6], X [5:3], Y [2:0]
    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int X_MSB   = 5;
    localparam int X_LSB   = 3;
    localparam int Y_MSB   = 2;
    localparam int Y_LSB   = 0;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_IMM       = 3'd3,
        S_WAIT_DONE = 3'd4
    } fetch_state_t;

    function automatic logic [2:0] opcode_of(input word_t w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus between the instruction feeder, the program ROM and the processor.
//   ADDR     : ROM address (feeder -> ROM)
//   ROM_DATA : ROM read data, one cycle after ADDR (ROM -> feeder)
//   DIN      : instruction / immediate word (feeder -> processor)
//   Run      : one-cycle issue strobe (feeder -> processor)
//   Done     : instruction-complete strobe (processor -> feeder)
// Modports: master = feeder side, slave = ROM/processor side.
interface instr_fetch_if #(
    parameter int ADDR_W = 5
);
    import proc_pkg::*;

    logic [ADDR_W-1:0] ADDR;
    word_t             ROM_DATA;
    word_t             DIN;
    logic              Run;
    logic              Done;

    modport master (
        output ADDR, DIN, Run,
        input  ROM_DATA, Done
    );

    modport slave (
        input  ADDR, DIN, Run,
        output ROM_DATA, Done
    );

endinterface

// File: rtl/instr_fetch_pc_counter.sv
// Program counter: ADDR_W-bit wrap-around incrementer with synchronous load,
// increment enable and asynchronous active-low clear.
//   Clock, Resetn : clock / async clear
//   load_i, load_val_i : load a new PC (load has priority over increment)
//   inc_i         : advance PC by one, wrapping at 2^ADDR_W
//   pc_o          : current PC
//   pc_next_o     : PC+1 (combinational), used for look-ahead addressing
module pc_counter #(
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_next_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    assign pc_next_o = pc_q + ADDR_W'(1);
    assign pc_o      = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_next_o;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction feeder for the 9-bit bus processor. Walks the PC through a
// 1-cycle synchronous ROM, issues each instruction on DIN with a one-cycle
// Run pulse, supplies the mvi immediate on the following cycle and waits for
// Done before fetching the next instruction.
//   Clock, Resetn : clock / async active-low reset
//   Go            : level; fetch and issue while high
//   bus (master)  : ADDR, ROM_DATA, DIN, Run, Done
//   Busy          : high in every state except IDLE
//   PC            : program counter (debug)
//   Error         : sticky Done timeout flag
// Optional feature macro: INSTR_FETCH_WATCHDOG_EN (Done watchdog). Without it
// the block waits for Done indefinitely and Error is constant 0.
//
// state     | meaning
// IDLE      | parked, ADDR=PC, waiting for Go
// FETCH     | ADDR=PC presented to ROM
// ISSUE     | DIN=instruction, Run=1, ADDR=PC+1 (prefetch immediate)
// IMM       | DIN=immediate for an mvi
// WAIT_DONE | waiting for the processor's Done
module instr_fetch
    import proc_pkg::*;
#(
    parameter int         ADDR_W  = 5,
    parameter logic [2:0] OPC_MVI = proc_pkg::OPC_MVI,
    parameter int         TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Go,
    instr_fetch_if.master     bus,
    output logic              Busy,
    output logic [ADDR_W-1:0] PC,
    output logic              Error
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_plus1;
    logic              pc_inc;
    logic              in_wait;
    logic              wd_timeout;
    logic              go_ok;

    pc_counter #(.ADDR_W(ADDR_W)) u_pc (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (pc_inc),
        .pc_o       (pc_q),
        .pc_next_o  (pc_plus1)
    );

    assign PC      = pc_q;
    assign in_wait = (state_q == S_IMM) || (state_q == S_WAIT_DONE);

`ifdef INSTR_FETCH_WATCHDOG_EN
    localparam int WD_W = 5;

    logic [WD_W-1:0] wd_cnt_q;
    logic            error_q;

    // Counter is held at zero outside the wait states, so it starts from zero
    // on every entry and runs across an IMM -> WAIT_DONE hand-over.
    assign wd_timeout = in_wait && !bus.Done && (wd_cnt_q == WD_W'(TIMEOUT - 1));
    assign go_ok      = !error_q;
    assign Error      = error_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wd_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            if (!in_wait) begin
                wd_cnt_q <= '0;
            end else if (!bus.Done) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
            if (wd_timeout) begin
                error_q <= 1'b1;
            end
        end
    end
`else
    logic [31:0] timeout_unused;

    assign timeout_unused = TIMEOUT;
    assign wd_timeout     = 1'b0;
    assign go_ok          = 1'b1;
    assign Error          = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Go && go_ok) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (opcode_of(bus.ROM_DATA) == OPC_MVI) begin
                    pc_inc  = 1'b1;
                    state_d = S_IMM;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_IMM, S_WAIT_DONE: begin
                if (bus.Done) begin
                    pc_inc  = 1'b1;
                    state_d = Go ? S_FETCH : S_IDLE;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (wd_timeout) begin
            state_d = S_IDLE;
            pc_inc  = 1'b0;
        end
    end

    // ISSUE looks one word ahead so the mvi immediate arrives in IMM.
    always_comb begin
        bus.ADDR = pc_q;
        bus.DIN  = '0;
        bus.Run  = 1'b0;
        Busy     = (state_q != S_IDLE);
        case (state_q)
            S_ISSUE: begin
                bus.ADDR = pc_plus1;
                bus.DIN  = bus.ROM_DATA;
                bus.Run  = 1'b1;
            end
            S_IMM: begin
                bus.DIN = bus.ROM_DATA;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import proc_pkg::*;

    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          Clock  = 1'b0;
    logic          Resetn = 1'b0;
    logic          Go     = 1'b0;
    logic          Busy;
    logic          Error;
    logic [AW-1:0] PC;

    instr_fetch_if #(.ADDR_W(AW)) bus();

    logic [8:0] rom [DEPTH];

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int m_pc        = 0;
    int exp_run_cyc = 0;

    always #5 Clock = ~Clock;

    always @(posedge Clock) bus.ROM_DATA <= rom[bus.ADDR];

    instr_fetch #(.ADDR_W(AW)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Go     (Go),
        .bus    (bus),
        .Busy   (Busy),
        .PC     (PC),
        .Error  (Error)
    );

    task automatic tick();
        @(negedge Clock);
        cyc++;
    endtask

    task automatic do_reset();
        Go       = 1'b0;
        bus.Done = 1'b0;
        @(negedge Clock);
        Resetn = 1'b0;
        tick();
        tick();
        Resetn = 1'b1;
        cyc    = 0;
        m_pc   = 0;
    endtask

    task automatic wait_run(output bit ok);
        int n = 0;
        while (bus.Run !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        ok = (bus.Run === 1'b1);
        if (!ok) begin
            errors++;
            $display("FAIL run_timeout: Run=%b after %0d cycles, required 1", bus.Run, n);
        end
    endtask

    // Issue one instruction at the model PC, answer it with Done d cycles
    // after Run, optionally dropping Go in the first cycle after Run.
    task automatic one_instr(input int d, input bit drop_go);
        bit         ok;
        bit         mvi;
        logic [8:0] exp_din;
        wait_run(ok);
        if (!ok) return;
        checks++;
        if (cyc != exp_run_cyc) begin
            errors++;
            $display("FAIL run_cycle: Run at cycle %0d, required %0d", cyc, exp_run_cyc);
        end
        checks++;
        if (bus.DIN !== rom[m_pc]) begin
            errors++;
            $display("FAIL din_issue: DIN=%h, required %h (pc %0d)", bus.DIN, rom[m_pc], m_pc);
        end
        checks++;
        if (PC !== AW'(m_pc)) begin
            errors++;
            $display("FAIL pc_issue: PC=%0d, required %0d", PC, m_pc);
        end
        mvi = (rom[m_pc][8:6] == 3'b001);
        if (mvi) m_pc = (m_pc + 1) % DEPTH;
        for (int k = 1; k <= d; k++) begin
            tick();
            exp_din = (mvi && k == 1) ? rom[m_pc] : 9'h000;
            checks++;
            if (bus.DIN !== exp_din || bus.Run !== 1'b0 || Busy !== 1'b1) begin
                errors++;
                $display("FAIL wait_cycle: k=%0d DIN=%h Run=%b Busy=%b, required DIN=%h Run=0 Busy=1",
                         k, bus.DIN, bus.Run, Busy, exp_din);
            end
            if (drop_go && k == 1) Go = 1'b0;
            if (k == d) bus.Done = 1'b1;
        end
        tick();
        bus.Done = 1'b0;
        m_pc = (m_pc + 1) % DEPTH;
        checks++;
        if (PC !== AW'(m_pc)) begin
            errors++;
            $display("FAIL pc_after_done: PC=%0d, required %0d", PC, m_pc);
        end
        checks++;
        if (Busy !== Go) begin
            errors++;
            $display("FAIL busy_after_done: Busy=%b, required %b", Busy, Go);
        end
        exp_run_cyc = cyc + 1;
    endtask

    task automatic test_reset();
        Go       = 1'b0;
        bus.Done = 1'b0;
        Resetn   = 1'b0;
        #3;
        checks++;
        if (bus.Run !== 1'b0 || bus.DIN !== 9'h000 || Busy !== 1'b0 || PC !== '0 ||
            Error !== 1'b0 || bus.ADDR !== '0) begin
            errors++;
            $display("FAIL reset_values: Run=%b DIN=%h Busy=%b PC=%0d Error=%b ADDR=%0d, required all 0",
                     bus.Run, bus.DIN, Busy, PC, Error, bus.ADDR);
        end
    endtask

    task automatic test_mv();
        for (int i = 0; i < DEPTH; i++) rom[i] = 9'h000;
        rom[0] = 9'h00A;
        rom[1] = 9'h011;
        do_reset();
        Go = 1'b1;
        exp_run_cyc = cyc + 2;
        one_instr(1, 1'b0);
        one_instr(1, 1'b0);
    endtask

    task automatic test_mvi();
        for (int i = 0; i < DEPTH; i++) rom[i] = 9'h000;
        rom[0] = 9'h058;
        rom[1] = 9'h1A5;
        rom[2] = 9'h0CB;
        do_reset();
        Go = 1'b1;
        exp_run_cyc = cyc + 2;
        one_instr(1, 1'b0);
        one_instr(2, 1'b0);
    endtask

    task automatic test_wrap();
        int n = 0;
        rom[0] = 9'h07F;
        rom[1] = 9'h155;
        for (int i = 2; i < 31; i++) rom[i] = {3'b000, 6'($urandom)};
        rom[31] = 9'h050;
        do_reset();
        Go = 1'b1;
        exp_run_cyc = cyc + 2;
        while (m_pc != 31 && n < 40) begin
            one_instr(1, 1'b0);
            n++;
        end
        one_instr(1, 1'b0);
        checks++;
        if (PC !== AW'(1)) begin
            errors++;
            $display("FAIL wrap_pc: PC=%0d, required 1", PC);
        end
    endtask

    task automatic test_go_drop();
        for (int i = 0; i < DEPTH; i++) rom[i] = 9'h000;
        rom[0] = 9'h0A3;
        rom[1] = 9'h01C;
        do_reset();
        Go = 1'b1;
        exp_run_cyc = cyc + 2;
        one_instr(3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.Run !== 1'b0 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_drop: Run=%b Busy=%b, required 0 0", bus.Run, Busy);
            end
        end
        Go = 1'b1;
        exp_run_cyc = cyc + 2;
        one_instr(1, 1'b0);
    endtask

    task automatic test_async_reset();
        bit ok;
        for (int i = 0; i < DEPTH; i++) rom[i] = 9'h000;
        rom[0] = 9'h058;
        rom[1] = 9'h1A5;
        do_reset();
        Go = 1'b1;
        wait_run(ok);
        tick();
        checks++;
        if (bus.DIN !== 9'h1A5 || PC !== AW'(1)) begin
            errors++;
            $display("FAIL imm_before_reset: DIN=%h PC=%0d, required 1a5 1", bus.DIN, PC);
        end
        #1;
        Resetn = 1'b0;
        #1;
        checks++;
        if (bus.Run !== 1'b0 || bus.DIN !== 9'h000 || PC !== '0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: Run=%b DIN=%h PC=%0d Busy=%b, required 0 000 0 0",
                     bus.Run, bus.DIN, PC, Busy);
        end
        Go = 1'b0;
        tick();
        Resetn = 1'b1;
    endtask

    task automatic test_random();
        int  d;
        bit  drop;
        int  idle_n;
        for (int i = 0; i < DEPTH; i++) rom[i] = 9'($urandom);
        do_reset();
        Go = 1'b1;
        exp_run_cyc = cyc + 2;
        for (int i = 0; i < 40; i++) begin
            d    = $urandom_range(1, 4);
            drop = ($urandom_range(0, 5) == 0);
            one_instr(d, drop);
            if (drop) begin
                idle_n = $urandom_range(0, 3);
                for (int j = 0; j < idle_n; j++) begin
                    tick();
                    checks++;
                    if (bus.Run !== 1'b0 || Busy !== 1'b0) begin
                        errors++;
                        $display("FAIL random_idle: Run=%b Busy=%b, required 0 0", bus.Run, Busy);
                    end
                end
                Go = 1'b1;
                exp_run_cyc = cyc + 2;
            end
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        for (int i = 0; i < DEPTH; i++) rom[i] = 9'h000;
        rom[0] = 9'h0A3;
        do_reset();
        Go = 1'b1;
        wait_run(ok);
`ifdef INSTR_FETCH_WATCHDOG_EN
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if (Error !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_trip: Error=%b Busy=%b, required 1 0", Error, Busy);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.Run !== 1'b0 || Error !== 1'b1) begin
                errors++;
                $display("FAIL watchdog_hold: Run=%b Error=%b, required 0 1", bus.Run, Error);
            end
        end
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (Error !== 1'b0 || Busy !== 1'b1 || bus.Run !== 1'b0) begin
                errors++;
                $display("FAIL no_watchdog: Error=%b Busy=%b Run=%b, required 0 1 0",
                         Error, Busy, bus.Run);
            end
        end
`endif
        Go = 1'b0;
    endtask

    initial begin
        bus.Done = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom[i] = 9'h000;
        test_reset();
        test_mv();
        test_mvi();
        test_wrap();
        test_go_drop();
        test_async_reset();
        test_random();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
